// File: rtl/stack_alu_sequencer.sv
// stack_alu_sequencer: command sequencer/ALU that is the only master of a
// byte-wide LIFO stack without full/empty flags. Each host opcode becomes a
// series of single-cycle push/pop strobes. Depth is tracked locally.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        host command handshake (ready only in IDLE)
//   cmd_op, cmd_imm            opcode (PUSH,POP,ADD,SUB,AND,OR,XOR,DUP), immediate
//   res_valid                  one-cycle completion pulse
//   res_data, res_err          result byte and status (ok/underflow/overflow/timeout)
//   depth                      current stack entry count
//   stk_push, stk_pop          one-cycle strobes toward the stack
//   stk_wdata                  push data, held until the stack completes
//   stk_rdata                  pop data from the stack
//   stk_done                   stack idle level
module stack_alu_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned DW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [7:0]    cmd_imm,
  output logic          res_valid,
  output logic [7:0]    res_data,
  output logic [1:0]    res_err,
  output logic [DW-1:0] depth,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [7:0]    stk_wdata,
  input  logic [7:0]    stk_rdata,
  input  logic          stk_done
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, POP_B, WAIT_B, POP_A, WAIT_A, EXEC,
    PUSH1, WAIT_P1, PUSH2, WAIT_P2, RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_DUP
  } op_e;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVER  = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  state_e          state_q, state_n;
  op_e             op_q, op_n;
  logic [7:0]      imm_q, imm_n;
  logic [7:0]      a_q, a_n;
  logic [7:0]      b_q, b_n;
  logic [DW-1:0]   depth_q, depth_n;
  logic [TW-1:0]   tcnt_q, tcnt_n;
  logic [7:0]      wdata_q, wdata_n;
  logic            res_valid_q, res_valid_n;
  logic [7:0]      res_data_q, res_data_n;
  logic [1:0]      res_err_q, res_err_n;
  logic            started_q;

  logic [1:0]      need;
  logic            grows;
  logic [7:0]      alu_res;
  logic            in_wait;

  always_comb begin
    need  = 2'd2;
    grows = 1'b0;
    case (op_q)
      OP_PUSH: begin need = 2'd0; grows = 1'b1; end
      OP_POP:  need = 2'd1;
      OP_DUP:  begin need = 2'd1; grows = 1'b1; end
      default: need = 2'd2;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = a_q;
    endcase
  end

  assign in_wait = (state_q == WAIT_B) || (state_q == WAIT_A) ||
                   (state_q == WAIT_P1) || (state_q == WAIT_P2);

  // Strobe states last exactly one cycle and are only entered while
  // stk_done is high, so the strobes decode straight from the state register.
  always_comb begin
    state_n     = state_q;
    op_n        = op_q;
    imm_n       = imm_q;
    a_n         = a_q;
    b_n         = b_q;
    depth_n     = depth_q;
    tcnt_n      = tcnt_q;
    wdata_n     = wdata_q;
    res_valid_n = 1'b0;
    res_data_n  = res_data_q;
    res_err_n   = res_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n    = op_e'(cmd_op);
          imm_n   = cmd_imm;
          state_n = CHECK;
        end
      end
      CHECK: begin
        if (depth_q < DW'(need)) begin
          res_valid_n = 1'b1;
          res_err_n   = ERR_UNDER;
          res_data_n  = '0;
          state_n     = RESP;
        end else if (grows && (depth_q >= DW'(DEPTH))) begin
          res_valid_n = 1'b1;
          res_err_n   = ERR_OVER;
          res_data_n  = '0;
          state_n     = RESP;
        end else if (stk_done) begin
          tcnt_n = '0;
          case (op_q)
            OP_PUSH: begin wdata_n = imm_q; state_n = PUSH1; end
            OP_POP,
            OP_DUP:  state_n = POP_A;
            default: state_n = POP_B;
          endcase
        end
      end
      POP_B: state_n = WAIT_B;
      WAIT_B: begin
        if (stk_done) begin
          b_n     = stk_rdata;
          depth_n = depth_q - DW'(1);
          tcnt_n  = '0;
          state_n = POP_A;
        end
      end
      POP_A: state_n = WAIT_A;
      WAIT_A: begin
        if (stk_done) begin
          a_n     = stk_rdata;
          depth_n = depth_q - DW'(1);
          tcnt_n  = '0;
          case (op_q)
            OP_POP: begin
              res_valid_n = 1'b1;
              res_err_n   = ERR_OK;
              res_data_n  = stk_rdata;
              state_n     = RESP;
            end
            OP_DUP: begin
              wdata_n = stk_rdata;
              state_n = PUSH1;
            end
            default: state_n = EXEC;
          endcase
        end
      end
      EXEC: begin
        if (stk_done) begin
          wdata_n = alu_res;
          tcnt_n  = '0;
          state_n = PUSH1;
        end
      end
      PUSH1: state_n = WAIT_P1;
      WAIT_P1: begin
        if (stk_done) begin
          depth_n = depth_q + DW'(1);
          tcnt_n  = '0;
          if (op_q == OP_DUP) begin
            state_n = PUSH2;
          end else begin
            res_valid_n = 1'b1;
            res_err_n   = ERR_OK;
            res_data_n  = wdata_q;
            state_n     = RESP;
          end
        end
      end
      PUSH2: state_n = WAIT_P2;
      WAIT_P2: begin
        if (stk_done) begin
          depth_n     = depth_q + DW'(1);
          res_valid_n = 1'b1;
          res_err_n   = ERR_OK;
          res_data_n  = wdata_q;
          state_n     = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Shared timeout handling for every post-strobe wait; completed
    // strobes have already been folded into depth.
    if (in_wait && !stk_done) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        res_valid_n = 1'b1;
        res_err_n   = ERR_TMO;
        res_data_n  = '0;
        state_n     = RESP;
      end else begin
        tcnt_n = tcnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= OP_PUSH;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      depth_q     <= '0;
      tcnt_q      <= '0;
      wdata_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= '0;
      started_q   <= 1'b0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      imm_q       <= imm_n;
      a_q         <= a_n;
      b_q         <= b_n;
      depth_q     <= depth_n;
      tcnt_q      <= tcnt_n;
      wdata_q     <= wdata_n;
      res_valid_q <= res_valid_n;
      res_data_q  <= res_data_n;
      res_err_q   <= res_err_n;
      started_q   <= 1'b1;
    end
  end

  // started_q keeps cmd_ready low for the first cycle out of reset.
  assign cmd_ready = (state_q == IDLE) && started_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign depth     = depth_q;
  assign stk_push  = (state_q == PUSH1) || (state_q == PUSH2);
  assign stk_pop   = (state_q == POP_A) || (state_q == POP_B);
  assign stk_wdata = wdata_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
module tb_stack_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_imm = '0;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_err;
  logic [4:0] depth;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_wdata;
  logic [7:0] stk_rdata = '0;
  logic       stk_done = 1'b1;

  int checks = 0;
  int failures = 0;

  // Stack model state (written only by the model process)
  logic [7:0] smem[$];
  int busy = 0;
  int n_push = 0;
  int n_pop = 0;
  int mon_bad = 0;
  logic [7:0] wd_hold = '0;
  bit push_pend = 0;
  // Controls written only by the main initial block
  int lat_k = 1;
  int stall_at = -1;

  stack_alu_sequencer #(.DEPTH(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
    .depth(depth),
    .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_wdata(stk_wdata), .stk_rdata(stk_rdata), .stk_done(stk_done)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stack model: responds in lat_k cycles (stk_done low lat_k-1 cycles),
  // and records protocol violations in mon_bad.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smem.delete();
      busy = 0;
      stk_done = 1'b1;
      stk_rdata = '0;
      push_pend = 0;
    end else if (stk_push || stk_pop) begin
      if ((stk_push && stk_pop) || !stk_done) mon_bad++;
      if (stk_push) begin
        if (smem.size() < 16) smem.push_back(stk_wdata);
        n_push++;
        wd_hold = stk_wdata;
        push_pend = 1;
      end else begin
        push_pend = 0;
      end
      if (stk_pop) begin
        n_pop++;
        if (smem.size() > 0) stk_rdata = smem.pop_back();
        else stk_rdata = '0;
      end
      busy = (stk_pop && n_pop == stall_at) ? 40 : lat_k - 1;
      stk_done = (busy == 0);
    end else if (busy > 0) begin
      if (push_pend && stk_wdata !== wd_hold) mon_bad++;
      stk_done = 1'b0;
      busy--;
    end else begin
      stk_done = 1'b1;
    end
  end

  typedef struct {
    logic [2:0] op;
    logic [7:0] imm;
    logic [7:0] data;
    logic [1:0] err;
    int         dep;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] imm,
                       output logic [7:0] d, output logic [1:0] e, output int lat,
                       output bit ok, output int dp, output int dq, output int bad);
    int n;
    int p0, q0, b0;
    d = '0; e = '0; lat = 0; ok = 0; dp = 0; dq = 0; bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL accept op=%0d: cmd_ready got 0 expected 1", op);
      cmd_valid = 1'b0;
      return;
    end
    p0 = n_push; q0 = n_pop; b0 = mon_bad;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    while (lat < 300 && !ok) begin
      @(negedge clk);
      lat++;
      ok = res_valid;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL res_valid op=%0d: got none expected pulse within 300 cycles", op);
      return;
    end
    d = res_data; e = res_err;
    dp = n_push - p0; dq = n_pop - q0; bad = mon_bad - b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [7:0] imm,
                         input logic [7:0] ed, input logic [1:0] ee, input int edep);
    logic [7:0] d;
    logic [1:0] e;
    int lat, dp, dq, bad, xp, xq;
    bit ok;
    string tag;
    tag = $sformatf("op=%0d imm=%02h", op, imm);
    issue(op, imm, d, e, lat, ok, dp, dq, bad);
    if (!ok) return;
    chk({"res_err ", tag}, e, ee);
    if (ee == 2'd0) chk({"res_data ", tag}, d, ed);
    chk({"depth ", tag}, int'(depth), edep);
    if (ee != 2'd0) begin xp = 0; xq = 0; end
    else case (op)
      3'd0: begin xp = 1; xq = 0; end
      3'd1: begin xp = 0; xq = 1; end
      3'd7: begin xp = 2; xq = 1; end
      default: begin xp = 1; xq = 2; end
    endcase
    chk({"push_strobes ", tag}, dp, xp);
    chk({"pop_strobes ", tag}, dq, xq);
    chk({"protocol ", tag}, bad, 0);
    if (ee != 2'd0) chk({"latency_err ", tag}, lat, 2);
    else if (op == 3'd0 || op == 3'd1) chk({"latency ", tag}, lat, 3 + lat_k);
    @(negedge clk);
    chk({"res_valid_pulse ", tag}, int'(res_valid), 0);
    chk({"res_hold ", tag}, int'(res_data), int'(d));
  endtask

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd2: return 8'((int'(a) + int'(b)) % 256);
      3'd3: return 8'((int'(a) - int'(b) + 256) % 256);
      3'd4: return a & b;
      3'd5: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  initial begin
    vec_t tbl[$];
    logic [7:0] rq[$];
    logic [7:0] d, a, b, ed;
    logic [1:0] e, ee;
    logic [2:0] op;
    logic [7:0] imm;
    int lat, dp, dq, bad, n, seen;
    bit ok;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset cmd_ready first cycle", int'(cmd_ready), 0);
    chk("reset res_valid", int'(res_valid), 0);
    chk("reset res_data", int'(res_data), 0);
    chk("reset res_err", int'(res_err), 0);
    chk("reset depth", int'(depth), 0);
    chk("reset strobes", int'({stk_push, stk_pop}), 0);
    chk("reset stk_wdata", int'(stk_wdata), 0);
    @(posedge clk);
    #1 chk("cmd_ready after first cycle", int'(cmd_ready), 1);

    // Directed vectors
    tbl.push_back('{3'd0, 8'h12, 8'h12, 2'd0, 1});
    tbl.push_back('{3'd0, 8'h34, 8'h34, 2'd0, 2});
    tbl.push_back('{3'd2, 8'h00, 8'h46, 2'd0, 1});
    tbl.push_back('{3'd1, 8'h00, 8'h46, 2'd0, 0});
    tbl.push_back('{3'd0, 8'h05, 8'h05, 2'd0, 1});
    tbl.push_back('{3'd0, 8'h07, 8'h07, 2'd0, 2});
    tbl.push_back('{3'd3, 8'h00, 8'hFE, 2'd0, 1});
    tbl.push_back('{3'd0, 8'hFF, 8'hFF, 2'd0, 2});
    tbl.push_back('{3'd0, 8'h01, 8'h01, 2'd0, 3});
    tbl.push_back('{3'd2, 8'h00, 8'h00, 2'd0, 2});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 2'd0, 1});
    tbl.push_back('{3'd1, 8'h00, 8'hFE, 2'd0, 0});
    tbl.push_back('{3'd1, 8'h00, 8'h00, 2'd1, 0});
    tbl.push_back('{3'd4, 8'h00, 8'h00, 2'd1, 0});
    tbl.push_back('{3'd0, 8'hA5, 8'hA5, 2'd0, 1});
    tbl.push_back('{3'd7, 8'h00, 8'hA5, 2'd0, 2});
    tbl.push_back('{3'd1, 8'h00, 8'hA5, 2'd0, 1});
    tbl.push_back('{3'd1, 8'h00, 8'hA5, 2'd0, 0});
    for (int i = 0; i < 16; i++)
      tbl.push_back('{3'd0, 8'(i * 17), 8'(i * 17), 2'd0, i + 1});
    tbl.push_back('{3'd0, 8'h99, 8'h00, 2'd2, 16});
    tbl.push_back('{3'd7, 8'h00, 8'h00, 2'd2, 16});
    tbl.push_back('{3'd6, 8'h00, 8'h11, 2'd0, 15});
    tbl.push_back('{3'd1, 8'h00, 8'h11, 2'd0, 14});
    lat_k = 1;
    foreach (tbl[i]) run_cmd(tbl[i].op, tbl[i].imm, tbl[i].data, tbl[i].err, tbl[i].dep);

    // Randomized commands against a queue-based reference stack
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < ((i < 150) ? 4 : 7)) op = 3'd0;
      else op = 3'($urandom_range(1, 7));
      imm = 8'($urandom);
      lat_k = $urandom_range(1, 4);
      ee = 2'd0; ed = '0;
      case (op)
        3'd0: if (rq.size() >= 16) ee = 2'd2; else begin rq.push_back(imm); ed = imm; end
        3'd1: if (rq.size() < 1) ee = 2'd1; else ed = rq.pop_back();
        3'd7: begin
          if (rq.size() < 1) ee = 2'd1;
          else if (rq.size() >= 16) ee = 2'd2;
          else begin ed = rq[$]; rq.push_back(ed); end
        end
        default: begin
          if (rq.size() < 2) ee = 2'd1;
          else begin
            b = rq.pop_back(); a = rq.pop_back();
            ed = ref_alu(op, a, b);
            rq.push_back(ed);
          end
        end
      endcase
      run_cmd(op, imm, ed, ee, rq.size());
    end

    // Timeout on the second pop of XOR
    do_reset();
    lat_k = 1;
    run_cmd(3'd0, 8'h01, 8'h01, 2'd0, 1);
    run_cmd(3'd0, 8'h02, 8'h02, 2'd0, 2);
    run_cmd(3'd0, 8'h03, 8'h03, 2'd0, 3);
    stall_at = n_pop + 2;
    issue(3'd6, 8'h00, d, e, lat, ok, dp, dq, bad);
    if (ok) begin
      chk("timeout res_err", int'(e), 3);
      chk("timeout depth", int'(depth), 2);
      chk("timeout pops", dq, 2);
      chk("timeout pushes", dp, 0);
    end
    stall_at = -1;
    repeat (60) @(negedge clk);

    // Reset asserted during WAIT_A of AND
    do_reset();
    lat_k = 4;
    run_cmd(3'd0, 8'h0F, 8'h0F, 2'd0, 1);
    run_cmd(3'd0, 8'hF0, 8'hF0, 2'd0, 2);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_imm = '0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    seen = 0; n = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (stk_pop) seen++;
    end
    chk("and pops before reset", seen, 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset cmd_ready", int'(cmd_ready), 0);
    chk("midreset res_valid", int'(res_valid), 0);
    chk("midreset res_data", int'(res_data), 0);
    chk("midreset res_err", int'(res_err), 0);
    chk("midreset depth", int'(depth), 0);
    chk("midreset strobes", int'({stk_push, stk_pop}), 0);
    chk("midreset stk_wdata", int'(stk_wdata), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_k = 1;
    run_cmd(3'd0, 8'h3C, 8'h3C, 2'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
